// File: rtl/systolic_result_drain.sv
// systolic_result_drain
//   Consumer end of the systolic datapath's result-read interface. On a drain
//   request it walks the SIZE x SIZE accumulator array in row-major order,
//   drives the read selects, captures each returned sum into a 2-entry output
//   buffer and streams it out on a valid/ready port. The array is held
//   (mac_hold) for the whole drain; done pulses one cycle after the final
//   element has been accepted downstream.
//
//   Optional feature macro: SYSTOLIC_DRAIN_TAG_EN
//     When defined, adds res_row/res_col, carried through the buffer with each
//     element and reporting the (row, col) of res_msg.
//
// Ports
//   clk        clock
//   rst        synchronous reset, active-low
//   start_val  drain request valid
//   start_rdy  drain request ready (high only in IDLE)
//   mac_hold   high while draining; controller keeps mac_en low meanwhile
//   out_en     read enable to the datapath
//   out_rsel   row select to the datapath
//   out_csel   column select to the datapath
//   b_s_in     selected sum from the datapath (combinational, same cycle)
//   res_msg    result data
//   res_val    result valid
//   res_rdy    result ready
//   res_last   marks the element at (SIZE-1, SIZE-1)
//   done       one-cycle pulse at drain completion
//   res_row    (tag build) row of res_msg
//   res_col    (tag build) column of res_msg
module systolic_result_drain #(
  parameter int SIZE  = 4,
  parameter int NBITS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_val,
  output logic                     start_rdy,
  output logic                     mac_hold,
  output logic                     out_en,
  output logic [$clog2(SIZE)-1:0]  out_rsel,
  output logic [$clog2(SIZE)-1:0]  out_csel,
  input  logic [NBITS-1:0]         b_s_in,
  output logic [NBITS-1:0]         res_msg,
  output logic                     res_val,
  input  logic                     res_rdy,
  output logic                     res_last,
`ifdef SYSTOLIC_DRAIN_TAG_EN
  output logic [$clog2(SIZE)-1:0]  res_row,
  output logic [$clog2(SIZE)-1:0]  res_col,
`endif
  output logic                     done
);

  localparam int IW = $clog2(SIZE);
  localparam logic [IW-1:0] IDX_MAX = IW'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   row_p0, col_p0;
  logic            at_last_p0;
  logic            deq;
  logic            done_p2;

  // Output buffer: entry 0 is the head presented downstream.
  logic [1:0]      cnt_p1;
  logic [NBITS-1:0] msg0_p1, msg1_p1;
  logic            last0_p1, last1_p1;
`ifdef SYSTOLIC_DRAIN_TAG_EN
  logic [IW-1:0]   row0_p1, row1_p1, col0_p1, col1_p1;
`endif

  assign at_last_p0 = (row_p0 == IDX_MAX) && (col_p0 == IDX_MAX);
  assign res_val    = (cnt_p1 != 2'd0);
  assign deq        = res_val && res_rdy;
  assign res_msg    = msg0_p1;
  assign res_last   = last0_p1;
  assign out_rsel   = row_p0;
  assign out_csel   = col_p0;
  assign done       = done_p2;
`ifdef SYSTOLIC_DRAIN_TAG_EN
  assign res_row    = row0_p1;
  assign res_col    = col0_p1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Issue is gated by the registered buffer count only, so res_rdy never
  // reaches out_en combinationally.
  always_comb begin
    state_nxt = state;
    start_rdy = 1'b0;
    mac_hold  = 1'b0;
    out_en    = 1'b0;
    case (state)
      IDLE: begin
        start_rdy = 1'b1;
        if (start_val) state_nxt = DRAIN;
      end
      DRAIN: begin
        mac_hold = 1'b1;
        if (cnt_p1 < 2'd2) begin
          out_en = 1'b1;
          if (at_last_p0) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        mac_hold = 1'b1;
        if (deq && last0_p1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: row/column walk; selects hold the last index in FLUSH ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_p0 <= '0;
      col_p0 <= '0;
    end else begin
      case (state)
        IDLE: begin
          row_p0 <= '0;
          col_p0 <= '0;
        end
        DRAIN: begin
          if (out_en && !at_last_p0) begin
            if (col_p0 == IDX_MAX) begin
              col_p0 <= '0;
              row_p0 <= row_p0 + IW'(1);
            end else begin
              col_p0 <= col_p0 + IW'(1);
            end
          end
        end
        FLUSH: begin
          if (state_nxt == IDLE) begin
            row_p0 <= '0;
            col_p0 <= '0;
          end
        end
        default: begin
          row_p0 <= '0;
          col_p0 <= '0;
        end
      endcase
    end
  end

  // ---- stage p1: 2-entry output buffer ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_p1   <= 2'd0;
      msg0_p1  <= '0;
      msg1_p1  <= '0;
      last0_p1 <= 1'b0;
      last1_p1 <= 1'b0;
`ifdef SYSTOLIC_DRAIN_TAG_EN
      row0_p1  <= '0;
      row1_p1  <= '0;
      col0_p1  <= '0;
      col1_p1  <= '0;
`endif
    end else begin
      if (out_en && deq) begin
        // Count unchanged; the element behind the head (or the new one) moves up.
        if (cnt_p1 == 2'd1) begin
          msg0_p1  <= b_s_in;
          last0_p1 <= at_last_p0;
`ifdef SYSTOLIC_DRAIN_TAG_EN
          row0_p1  <= row_p0;
          col0_p1  <= col_p0;
`endif
        end else begin
          msg0_p1  <= msg1_p1;
          last0_p1 <= last1_p1;
          msg1_p1  <= b_s_in;
          last1_p1 <= at_last_p0;
`ifdef SYSTOLIC_DRAIN_TAG_EN
          row0_p1  <= row1_p1;
          col0_p1  <= col1_p1;
          row1_p1  <= row_p0;
          col1_p1  <= col_p0;
`endif
        end
      end else if (out_en) begin
        cnt_p1 <= cnt_p1 + 2'd1;
        if (cnt_p1 == 2'd0) begin
          msg0_p1  <= b_s_in;
          last0_p1 <= at_last_p0;
`ifdef SYSTOLIC_DRAIN_TAG_EN
          row0_p1  <= row_p0;
          col0_p1  <= col_p0;
`endif
        end else begin
          msg1_p1  <= b_s_in;
          last1_p1 <= at_last_p0;
`ifdef SYSTOLIC_DRAIN_TAG_EN
          row1_p1  <= row_p0;
          col1_p1  <= col_p0;
`endif
        end
      end else if (deq) begin
        cnt_p1 <= cnt_p1 - 2'd1;
        if (cnt_p1 == 2'd2) begin
          msg0_p1  <= msg1_p1;
          last0_p1 <= last1_p1;
`ifdef SYSTOLIC_DRAIN_TAG_EN
          row0_p1  <= row1_p1;
          col0_p1  <= col1_p1;
`endif
        end
      end
    end
  end

  // ---- stage p2: completion pulse after the last element leaves ----
  always_ff @(posedge clk) begin
    if (!rst) done_p2 <= 1'b0;
    else      done_p2 <= (state == FLUSH) && deq && last0_p1;
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Testbench for systolic_result_drain (SIZE=4, NBITS=16). The datapath is
// modelled as s[r][c] = 16*r + c gated by out_en.
module tb_systolic_result_drain;

  localparam int SIZE  = 4;
  localparam int NBITS = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_val;
  logic             start_rdy;
  logic             mac_hold;
  logic             out_en;
  logic [1:0]       out_rsel;
  logic [1:0]       out_csel;
  logic [NBITS-1:0] b_s_in;
  logic [NBITS-1:0] res_msg;
  logic             res_val;
  logic             res_rdy;
  logic             res_last;
  logic             done;
`ifdef SYSTOLIC_DRAIN_TAG_EN
  logic [1:0]       res_row;
  logic [1:0]       res_col;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign b_s_in = out_en ? NBITS'(16 * int'(out_rsel) + int'(out_csel)) : '0;

  systolic_result_drain #(.SIZE(SIZE), .NBITS(NBITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_val (start_val),
    .start_rdy (start_rdy),
    .mac_hold  (mac_hold),
    .out_en    (out_en),
    .out_rsel  (out_rsel),
    .out_csel  (out_csel),
    .b_s_in    (b_s_in),
    .res_msg   (res_msg),
    .res_val   (res_val),
    .res_rdy   (res_rdy),
    .res_last  (res_last),
`ifdef SYSTOLIC_DRAIN_TAG_EN
    .res_row   (res_row),
    .res_col   (res_col),
`endif
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int expv(input int idx);
    return 16 * (idx / 4) + (idx % 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a drain request until accepted; returns in cycle 1 of the drain.
  task automatic start_drain();
    int w = 0;
    start_val = 1'b1;
    while (!start_rdy && w < 100) begin
      tick();
      w++;
    end
    chk("start_accept", start_rdy, 1);
    tick();
    start_val = 1'b0;
  endtask

  // Consume a drain until done; mode 0 = ready always, 1 = random ready.
  task automatic collect(input int mode, input bit poke_start);
    int idx = 0;
    int dones = 0;
    int cyc = 0;
    bit fin = 1'b0;
    while (!fin && cyc < 400) begin
      res_rdy   = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      start_val = poke_start && (cyc == 4);
      if (poke_start && cyc == 4) chk("start_rdy_mid_drain", start_rdy, 0);
      if (done) begin
        dones++;
        fin = 1'b1;
      end
      if (res_val && res_rdy) begin
        chk("res_msg", res_msg, expv(idx));
        chk("res_last", res_last, (idx == 15) ? 1 : 0);
`ifdef SYSTOLIC_DRAIN_TAG_EN
        chk("res_row", res_row, idx / 4);
        chk("res_col", res_col, idx % 4);
`endif
        idx++;
      end
      tick();
      cyc++;
    end
    start_val = 1'b0;
    chk("drain_finished", fin, 1);
    chk("elem_count", idx, 16);
    chk("done_count", dones, 1);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    int issues;
    int acc;
    int w;
    rst       = 1'b0;
    start_val = 1'b0;
    res_rdy   = 1'b0;

    // Reset then idle
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_start_rdy", start_rdy, 1);
    chk("rst_res_val", res_val, 0);
    chk("rst_res_msg", res_msg, 0);
    chk("rst_out_en", out_en, 0);
    chk("rst_mac_hold", mac_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_rsel", out_rsel, 0);

    // Full-speed drain with exact cycle timing
    res_rdy = 1'b1;
    start_drain();
    for (int k = 1; k <= 19; k++) begin
      chk("fs_mac_hold", mac_hold, (k <= 17) ? 1 : 0);
      chk("fs_out_en", out_en, (k <= 16) ? 1 : 0);
      chk("fs_done", done, (k == 18) ? 1 : 0);
      chk("fs_res_val", res_val, (k >= 2 && k <= 17) ? 1 : 0);
      if (k >= 2 && k <= 17) begin
        chk("fs_res_msg", res_msg, expv(k - 2));
        chk("fs_res_last", res_last, (k == 17) ? 1 : 0);
`ifdef SYSTOLIC_DRAIN_TAG_EN
        chk("fs_res_row", res_row, (k - 2) / 4);
        chk("fs_res_col", res_col, (k - 2) % 4);
`endif
      end
      if (k == 17) chk("fs_sel_hold_last", {out_rsel, out_csel}, 4'hF);
      if (k == 18) chk("fs_sel_zero", {out_rsel, out_csel}, 0);
      tick();
    end

    // Backpressure: ready low for cycles 1..10
    res_rdy = 1'b0;
    start_drain();
    issues = 0;
    for (int k = 1; k <= 10; k++) begin
      if (out_en) issues++;
      if (k >= 2) begin
        chk("bp_res_val", res_val, 1);
        chk("bp_res_msg_stable", res_msg, 0);
`ifdef SYSTOLIC_DRAIN_TAG_EN
        chk("bp_res_row", res_row, 0);
        chk("bp_res_col", res_col, 0);
`endif
      end
      tick();
    end
    chk("bp_issue_count", issues, 2);
    chk("bp_out_en_off", out_en, 0);
    collect(0, 1'b0);

    // Three back-to-back drains with random ready; one carries a stray start
    for (int d = 0; d < 3; d++) begin
      start_drain();
      collect(1, d == 1);
    end

    // Mid-drain reset after the 5th accepted element
    res_rdy = 1'b1;
    start_drain();
    acc = 0;
    w = 0;
    while (acc < 5 && w < 100) begin
      if (res_val && res_rdy) acc++;
      tick();
      w++;
    end
    chk("mr_accepted", acc, 5);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mr_res_val", res_val, 0);
    chk("mr_out_en", out_en, 0);
    chk("mr_start_rdy", start_rdy, 1);
    chk("mr_mac_hold", mac_hold, 0);
    chk("mr_done", done, 0);
    start_drain();
    collect(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Consumer end of the systolic datapath's result-read interface (out_en / out_rsel / out_csel -> b_s_out).
- On a drain request, it walks the SIZE x SIZE accumulator array in row-major order and drives the select lines.
- It captures each returned sum and streams it out on a val/rdy port through a 2-entry output buffer.
- It holds the array (mac_hold) for the whole drain and pulses done after the last element is accepted downstream.

Parameters:
- SIZE, 4: array dimension; power of two, >= 2.
- NBITS, 16: sum width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low (asserted when 0).
- start_val  in  1  drain request valid.
- start_rdy  out  1  drain request ready; high only in IDLE.
- mac_hold  out  1  high while draining; controller must deassert mac_en while this is high.
- out_en  out  1  read-enable to datapath.
- out_rsel  out  $clog2(SIZE)  row select to datapath.
- out_csel  out  $clog2(SIZE)  column select to datapath.
- b_s_in  in  NBITS  selected sum from datapath; combinational, same-cycle.
- res_msg  out  NBITS  result data.
- res_val  out  1  result valid.
- res_rdy  in  1  result ready.
- res_last  out  1  high with the element at index (SIZE-1, SIZE-1).
- done  out  1  one-cycle pulse at drain completion.

Behaviour:
- Reset (rst==0 at a clk edge) puts the block in IDLE with:
  - start_rdy=1; mac_hold=0; out_en=0; out_rsel=0; out_csel=0.
  - Buffer empty: res_val=0, res_msg=0, res_last=0.
  - done=0.
  - Applies mid-drain as well; the partial drain is abandoned and nothing is emitted.
- IDLE:
  - start_rdy=1.
  - start_val && start_rdy at an edge -> DRAIN; row/col counters set to 0; issued count set to 0.
- DRAIN:
  - mac_hold=1, start_rdy=0, start_val ignored.
  - Issue condition: buffer count < 2, evaluated on the registered count, excluding the same-cycle dequeue. This keeps res_rdy off any combinational path to out_en.
  - Issue cycle: out_en=1; out_rsel/out_csel = current row/col. The same edge writes b_s_in into the buffer tail, with res_last = (row==SIZE-1 && col==SIZE-1).
  - After an issue: col++. At col==SIZE-1, col wraps to 0 and row++.
  - After the SIZE*SIZE-th issue: out_en stays 0; selects hold the last index; state -> FLUSH.
  - Non-issue cycle: out_en=0, selects hold their values.
- FLUSH:
  - mac_hold=1; no issues; waits for the buffer to empty.
  - The edge on which the res_last element is dequeued (res_val && res_rdy) -> IDLE.
  - done=1 in the cycle after that edge, for exactly one cycle.
  - Selects return to 0 on the FLUSH -> IDLE edge.
- Output buffer:
  - 2-entry FIFO; res_msg/res_val/res_last come from the head register.
  - Enqueue and dequeue may occur in the same cycle; count is unchanged in that case.
  - res_val is never deasserted or its data changed while res_rdy==0.
- Latency and throughput:
  - First issue occurs in the cycle after start is accepted.
  - First res_val is seen 1 cycle after the first issue.
  - With res_rdy held high: 1 element/cycle, count holds at 1. The full drain takes SIZE*SIZE+2 cycles from start acceptance to done.
- Arithmetic: none; data passes through unmodified.
  - The datapath ANDs its output with out_en, so b_s_in is only captured on issue cycles.

Optional Feature:
- Macro: SYSTOLIC_DRAIN_TAG_EN.
- Defined:
  - Adds output ports res_row and res_col, each $clog2(SIZE) bits.
  - Both are stored in the buffer alongside each element and report the (row, col) of res_msg.
  - Reset value 0.
- Undefined: these ports and their storage do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, then rst=1 -> start_rdy=1, res_val=0, out_en=0, mac_hold=0, done=0.
- Full-speed drain, SIZE=4, array s[r][c]=16*r+c, res_rdy=1 -> stimulus and timing:
  - Start accepted at cycle 0; res_msg = 0, 1, 2 ... 51 (row-major) in cycles 2..17.
  - res_last only with 51; done at cycle 18; mac_hold high for cycles 1..17.
- Backpressure: res_rdy=0 for cycles 1..10 -> exactly 2 issues, then out_en=0; res_msg holds 0 stable; releasing res_rdy resumes the sequence with no loss or duplication.
- Random res_rdy (50%), 3 back-to-back drains -> each yields 16 in-order values and exactly one done pulse; a start_val asserted mid-drain is not accepted.
- Mid-drain reset: rst=0 after the 5th element is accepted -> next cycle res_val=0, out_en=0, IDLE; a new drain then restarts from s[0][0].
- SYSTOLIC_DRAIN_TAG_EN defined -> res_row/res_col match (index>>2, index&3) for all 16 elements, including under backpressure.
